// File: rtl/shift_retire_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_retire_stage_pkg
// Description : Shared definitions for the shift retire stage.
//               - Bit positions of {N,Z,C,V} inside the flags register.
//               - Buffered entry layout (result, destination, flag controls
//                 and the precomputed N/Z values).
// Revision    : 1.0 - initial release
// ============================================================================
package shift_retire_stage_pkg;

    // Flag bit positions inside the 4-bit architectural flags register.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Entry field widths; the top-level DATA_W/DEST_W parameters default
    // to these and must stay equal to them.
    localparam int SRS_DATA_W = 32;
    localparam int SRS_DEST_W = 5;

    // One buffered shifter result. N and Z are computed at accept time so
    // the retire path only has to select between stored bits.
    typedef struct packed {
        logic [SRS_DATA_W-1:0] result;
        logic [SRS_DEST_W-1:0] dest;
        logic                  set_flags;
        logic                  pushed;
        logic                  shamt_zero;
        logic                  n;
        logic                  z;
    } retire_entry_t;

    localparam int RETIRE_ENTRY_W = $bits(retire_entry_t);

endpackage : shift_retire_stage_pkg
`default_nettype wire

// File: rtl/shift_retire_stage_retire_fifo.sv
`default_nettype none
// ============================================================================
// Module      : shift_retire_stage_retire_fifo
// Description : Generic in-order entry FIFO used by the shift retire stage.
//               Holds opaque ENTRY_W-bit entries; no knowledge of flags.
//               The caller must never push when full or pop when empty.
//               A flush empties the FIFO and wins over a same-cycle push.
//   Ports:
//     clk      - clock, rising edge
//     rst      - synchronous active-high reset (clears storage too, so the
//                head reads as zero after reset)
//     i_push   - write i_data at the tail
//     i_pop    - discard the head entry
//     i_flush  - empty the FIFO, pointers back to zero
//     i_data   - entry to write
//     o_head   - entry at the read pointer (straight from storage)
//     o_count  - number of valid entries, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module shift_retire_stage_retire_fifo #(
    parameter int ENTRY_W = 8,
    parameter int DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [ENTRY_W-1:0]       i_data,
    output logic [ENTRY_W-1:0]       o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            // Storage is left as is; only the bookkeeping is cleared.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : shift_retire_stage_retire_fifo
`default_nettype wire

// File: rtl/shift_retire_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_retire_stage
// Description : Execute-path stage after the shifter/rotator. Buffers
//               results in an in-order FIFO toward writeback and owns the
//               architectural {N,Z,C,V} flags for shift-class instructions.
//               Flags are written only when an entry retires (out_valid &
//               out_ready), so flushed entries never touch them.
//   Ports:
//     clk, reset        - clock / synchronous active-high reset
//     in_valid/in_ready - upstream handshake; in_ready is a decode of
//                         registered state only
//     in_result         - shifter result
//     in_pushed         - last bit shifted/rotated out
//     in_shamt_zero     - shift amount was zero (carry is kept)
//     in_set_flags      - instruction updates flags on retire
//     in_dest           - destination register index
//     flush             - drop buffered and same-cycle incoming entries
//     out_valid/out_ready - writeback handshake
//     out_result/out_dest - head entry contents
//     flags             - architectural {N,Z,C,V}
//     stall_cycles      - (SHIFT_RETIRE_PERF_EN only) saturating count of
//                         cycles with out_valid & ~out_ready
//   Build option: define SHIFT_RETIRE_PERF_EN to add the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_retire_stage
    import shift_retire_stage_pkg::*;
#(
    parameter int DATA_W    = SRS_DATA_W,
    parameter int DEST_W    = SRS_DEST_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_pushed,
    input  logic              in_shamt_zero,
    input  logic              in_set_flags,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic [3:0]        flags
`ifdef SHIFT_RETIRE_PERF_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(BUF_DEPTH - 1);

    // Occupancy states; the FIFO count is the source of truth for when
    // PARTIAL turns into EMPTY or FULL.
    localparam logic [1:0] c_ST_EMPTY   = 2'd0;
    localparam logic [1:0] c_ST_PARTIAL = 2'd1;
    localparam logic [1:0] c_ST_FULL    = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count;
    retire_entry_t     w_in_entry;
    retire_entry_t     w_head;
    logic [3:0]        r_flags;

    // ------------------------------------------------------------------
    // Handshakes. An incoming entry is dropped when flush is high; a
    // retire in the same cycle still completes.
    // ------------------------------------------------------------------
    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Entry build: N and Z are precomputed here.
    // ------------------------------------------------------------------
    always_comb begin
        w_in_entry            = '0;
        w_in_entry.result     = in_result;
        w_in_entry.dest       = in_dest;
        w_in_entry.set_flags  = in_set_flags;
        w_in_entry.pushed     = in_pushed;
        w_in_entry.shamt_zero = in_shamt_zero;
        w_in_entry.n          = in_result[DATA_W-1];
        w_in_entry.z          = (in_result == '0);
    end

    shift_retire_stage_retire_fifo #(
        .ENTRY_W (RETIRE_ENTRY_W),
        .DEPTH   (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_data  (w_in_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // ------------------------------------------------------------------
    // Occupancy FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        out_valid    = (r_state != c_ST_EMPTY);
        in_ready     = (r_state != c_ST_FULL);
        if (flush) begin
            w_state_next = c_ST_EMPTY;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    w_state_next = (w_count == c_CNT_LAST) ? c_ST_FULL : c_ST_PARTIAL;
                end
                2'b01: begin
                    w_state_next = (w_count == c_CNT_ONE) ? c_ST_EMPTY : c_ST_PARTIAL;
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Flag commit on retire. A zero shift amount leaves C untouched;
    // V is never written by shift-class instructions.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_pop && w_head.set_flags) begin
            r_flags[FLAG_N] <= w_head.n;
            r_flags[FLAG_Z] <= w_head.z;
            r_flags[FLAG_C] <= w_head.shamt_zero ? r_flags[FLAG_C] : w_head.pushed;
            r_flags[FLAG_V] <= r_flags[FLAG_V];
        end
    end

    assign flags      = r_flags;
    assign out_result = w_head.result;
    assign out_dest   = w_head.dest;

`ifdef SHIFT_RETIRE_PERF_EN
    // ------------------------------------------------------------------
    // Back-pressure counter, saturating at all ones.
    // ------------------------------------------------------------------
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (out_valid && !out_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule : shift_retire_stage
`default_nettype wire

// File: tb/tb_shift_retire_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_retire_stage
// Description : Directed, table-driven bench for shift_retire_stage. Each
//               record holds the inputs applied at one rising edge and the
//               outputs expected just after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_retire_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_pushed;
    logic        in_shamt_zero;
    logic        in_set_flags;
    logic [4:0]  in_dest;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic [3:0]  flags;
`ifdef SHIFT_RETIRE_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_retire_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_pushed     (in_pushed),
        .in_shamt_zero (in_shamt_zero),
        .in_set_flags  (in_set_flags),
        .in_dest       (in_dest),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_dest      (out_dest),
        .flags         (flags)
`ifdef SHIFT_RETIRE_PERF_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] res;
        logic        pushed;
        logic        sz;
        logic        sf;
        logic [4:0]  dest;
        logic        fl;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic        e_chk;    // compare out_result/out_dest
        logic [31:0] e_res;
        logic [4:0]  e_dest;
        logic [3:0]  e_flags;
    } vec_t;

    localparam int NV = 21;
    vec_t tv [NV];

    task automatic chk(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        reset         = v.rst;
        in_valid      = v.iv;
        in_result     = v.res;
        in_pushed     = v.pushed;
        in_shamt_zero = v.sz;
        in_set_flags  = v.sf;
        in_dest       = v.dest;
        flush         = v.fl;
        out_ready     = v.ordy;
        @(posedge clk);
        #1;
        chk("out_valid", idx, {31'd0, out_valid}, {31'd0, v.e_ov});
        chk("in_ready",  idx, {31'd0, in_ready},  {31'd0, v.e_ir});
        chk("flags",     idx, {28'd0, flags},     {28'd0, v.e_flags});
        if (v.e_chk) begin
            chk("out_result", idx, out_result, v.e_res);
            chk("out_dest",   idx, {27'd0, out_dest}, {27'd0, v.e_dest});
        end
    endtask

    initial begin
        // rst iv   res            pu    sz    sf    dest   fl    ordy  | ov    ir    chk   res            dest   flags
        // reset, then idle
        tv[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         5'd0,  4'b0000};
        tv[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         5'd0,  4'b0000};
        // zero result, pushed=1: one-cycle latency, then Z and C set
        tv[2]  = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b1, 5'd1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,         5'd1,  4'b0000};
        tv[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         5'd0,  4'b0110};
        // negative result with zero shift amount keeps C=1
        tv[4]  = '{1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 5'd3,  4'b0110};
        tv[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         5'd0,  4'b1010};
        // set_flags=0 retire leaves flags alone
        tv[6]  = '{1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,         5'd4,  4'b1010};
        tv[7]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         5'd0,  4'b1010};
        // A, B, C back-to-back with writeback stalled; C held off when full
        tv[8]  = '{1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA_0001, 5'd5,  4'b1010};
        tv[9]  = '{1'b0, 1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0, 5'd6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 5'd5,  4'b1010};
        tv[10] = '{1'b0, 1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 5'd5,  4'b1010};
        // full + pop + in_valid: no push, one entry left, in_ready back
        tv[11] = '{1'b0, 1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBBBB_0002, 5'd6,  4'b1010};
        // push C and pop B together
        tv[12] = '{1'b0, 1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hCCCC_0003, 5'd7,  4'b1010};
        tv[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         5'd0,  4'b1000};
        // fill with set_flags entries, flush with an incoming entry
        tv[14] = '{1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 5'd8,  4'b1000};
        tv[15] = '{1'b0, 1'b1, 32'hFFFF_0000, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 5'd8,  4'b1000};
        tv[16] = '{1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         5'd0,  4'b1000};
        tv[17] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         5'd0,  4'b1000};
        // flush with a same-cycle retire still commits flags
        tv[18] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,         5'd11, 4'b1000};
        tv[19] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         5'd0,  4'b0110};
        tv[20] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         5'd0,  4'b0110};

        for (int i = 0; i < NV; i++) begin
            step(tv[i], i);
        end

        // Reset mid-stream with two buffered entries: reset beats the
        // same-cycle retire, so no flags are committed.
        step('{1'b0, 1'b1, 32'h0F0F_0F0F, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b1, 32'h0F0F_0F0F, 5'd12, 4'b0110}, 100);
        step('{1'b0, 1'b1, 32'hF0F0_F0F0, 1'b1, 1'b0, 1'b1, 5'd13, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b1, 32'h0F0F_0F0F, 5'd12, 4'b0110}, 101);
        step('{1'b1, 1'b1, 32'h5555_5555, 1'b1, 1'b0, 1'b1, 5'd14, 1'b0, 1'b1,
               1'b0, 1'b1, 1'b1, 32'h0,         5'd0,  4'b0000}, 102);
        step('{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0,
               1'b0, 1'b1, 1'b1, 32'h0,         5'd0,  4'b0000}, 103);
        // Stage is usable again after reset.
        step('{1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 5'd15, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b1, 32'h0000_0001, 5'd15, 4'b0000}, 104);
        step('{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1,
               1'b0, 1'b1, 1'b0, 32'h0,         5'd0,  4'b0000}, 105);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_shift_retire_stage
`default_nettype wire
